// File: rtl/keypad_pkg.sv
// Shared keypad definitions: event encoding, key indices, default sizes.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package keypad_pkg;

    // Event type bit stored alongside the key index in the event FIFO
    localparam logic EVT_SHORT = 1'b0;
    localparam logic EVT_LONG  = 1'b1;

    // Key indices; S2 doubles as the calculator mode/clear key
    localparam logic [1:0] KEY_S0 = 2'd0;
    localparam logic [1:0] KEY_S1 = 2'd1;
    localparam logic [1:0] KEY_S2 = 2'd2;
    localparam logic [1:0] KEY_S3 = 2'd3;

    localparam int DEF_NUM_KEYS   = 4;
    localparam int DEF_FIFO_DEPTH = 4;

    // (base + off) mod modulus, valid for base < modulus and off < modulus,
    // so a single conditional subtract replaces a real modulo.
    function automatic int wrap_inc(input int base, input int off, input int modulus);
        int sum;
        sum = base + off;
        if (sum >= modulus) begin
            sum = sum - modulus;
        end
        return sum;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous first-word-fall-through FIFO for key events.
// Latency: a push is visible on dout/count after the writing edge; pop takes effect at the edge.
// Backpressure: full blocks pushes (ignored when full), pop while empty is ignored.
//
// Ports: clk_db/rst clock and async active-high reset; push/din write side;
// pop/dout read side (dout forced to 0 while empty); count/full/empty status.
module event_fifo #(
    parameter int WIDTH      = 3,
    parameter int FIFO_DEPTH = 4,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic             clk_db,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            // Depth is a power of two, so pointer wrap is natural overflow
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_db or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/key_event_arbiter.sv
// Latches per-key short/long press pulses and arbitrates them round-robin into an event FIFO.
// Latency: pulse at edge k -> FIFO write at edge k+1 -> evt_valid high after k+1 (2 cycles min).
// Backpressure: evt_valid/evt_ready; a full FIFO stalls grants and events wait in their latches.
//
// Ports: clk_db/rst clock and async active-high reset; short_press/long_press
// one-cycle pulses per key; evt_valid/evt_ready/evt_key/evt_long event handshake;
// pending_cnt FIFO occupancy; overflow sticky drop flag cleared by clr_overflow.
module key_event_arbiter
    import keypad_pkg::*;
#(
    parameter int NUM_KEYS   = DEF_NUM_KEYS,
    parameter int KEY_W      = 2,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_W      = 3
) (
    input  logic                clk_db,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] short_press,
    input  logic [NUM_KEYS-1:0] long_press,
    input  logic                evt_ready,
    input  logic                clr_overflow,
    output logic                evt_valid,
    output logic [KEY_W-1:0]    evt_key,
    output logic                evt_long,
    output logic [CNT_W-1:0]    pending_cnt,
    output logic                overflow
);

    logic [NUM_KEYS-1:0] pend_s_q, pend_s_d;
    logic [NUM_KEYS-1:0] pend_l_q, pend_l_d;
    logic [KEY_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                overflow_q, overflow_d;

    logic [NUM_KEYS-1:0] cand;
    logic [NUM_KEYS-1:0] gnt_s, gnt_l;
    logic [NUM_KEYS-1:0] drop_s, drop_l;
    logic                gnt_vld;
    logic                gnt_long;
    logic [KEY_W-1:0]    gnt_idx;
    logic [KEY_W-1:0]    scan_idx;

    logic                fifo_full;
    logic                fifo_empty;
    logic [KEY_W:0]      fifo_dout;

    always_comb begin
        cand     = pend_s_q | pend_l_q;
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        // First pending key at or after rr_ptr; full uses the registered count,
        // so a same-cycle pop never opens a slot early.
        for (int off = 0; off < NUM_KEYS; off++) begin
            scan_idx = KEY_W'(wrap_inc(int'(rr_ptr_q), off, NUM_KEYS));
            if (!gnt_vld && !fifo_full && cand[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_idx;
            end
        end
        // Long wins over short for the granted key
        gnt_long = pend_l_q[gnt_idx];

        gnt_s = '0;
        gnt_l = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            gnt_l[i] = gnt_vld && (gnt_idx == KEY_W'(i)) && gnt_long;
            gnt_s[i] = gnt_vld && (gnt_idx == KEY_W'(i)) && !gnt_long;
        end

        // A pulse onto a latch that is being granted this cycle simply re-arms it
        drop_s   = short_press & pend_s_q & ~gnt_s;
        drop_l   = long_press  & pend_l_q & ~gnt_l;
        pend_s_d = (pend_s_q & ~gnt_s) | short_press;
        pend_l_d = (pend_l_q & ~gnt_l) | long_press;

        rr_ptr_d = gnt_vld ? KEY_W'(wrap_inc(int'(gnt_idx), 1, NUM_KEYS)) : rr_ptr_q;

        // Set dominates clear
        overflow_d = (|drop_s) || (|drop_l) || (overflow_q && !clr_overflow);
    end

    always_ff @(posedge clk_db or posedge rst) begin
        if (rst) begin
            pend_s_q   <= '0;
            pend_l_q   <= '0;
            rr_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            pend_s_q   <= pend_s_d;
            pend_l_q   <= pend_l_d;
            rr_ptr_q   <= rr_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    event_fifo #(
        .WIDTH      (KEY_W + 1),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_event_fifo (
        .clk_db (clk_db),
        .rst    (rst),
        .push   (gnt_vld),
        .pop    (evt_valid && evt_ready),
        .din    ({gnt_idx, gnt_long}),
        .dout   (fifo_dout),
        .count  (pending_cnt),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign evt_valid = !fifo_empty;
    assign evt_key   = fifo_dout[KEY_W:1];
    assign evt_long  = fifo_dout[0];
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Self-checking bench for key_event_arbiter: directed scenarios followed by
// random pulse/ready traffic, all compared against a queue-based event model.
module tb_key_event_arbiter;

    localparam int NK    = 4;
    localparam int DEPTH = 4;

    logic          clk_db = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] short_press = '0;
    logic [NK-1:0] long_press = '0;
    logic          evt_ready = 1'b0;
    logic          clr_overflow = 1'b0;
    logic          evt_valid;
    logic [1:0]    evt_key;
    logic          evt_long;
    logic [2:0]    pending_cnt;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending flags per key, event queue (key*2+long), RR start, sticky flag
    bit m_s [NK];
    bit m_l [NK];
    int m_q [$];
    int m_rr;
    bit m_ovf;

    always #5 clk_db = ~clk_db;

    key_event_arbiter dut (
        .clk_db       (clk_db),
        .rst          (rst),
        .short_press  (short_press),
        .long_press   (long_press),
        .evt_ready    (evt_ready),
        .clr_overflow (clr_overflow),
        .evt_valid    (evt_valid),
        .evt_key      (evt_key),
        .evt_long     (evt_long),
        .pending_cnt  (pending_cnt),
        .overflow     (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < NK; k++) begin
            m_s[k] = 1'b0;
            m_l[k] = 1'b0;
        end
        m_q.delete();
        m_rr  = 0;
        m_ovf = 1'b0;
    endfunction

    // One clock edge of the arbiter, computed from the pre-edge inputs
    function automatic void model_edge(input logic [NK-1:0] sp, input logic [NK-1:0] lp,
                                       input logic rdy, input logic clr);
        int g;
        bit gl;
        bit drop;
        g    = -1;
        gl   = 1'b0;
        drop = 1'b0;
        if (m_q.size() < DEPTH) begin
            for (int off = 0; off < NK; off++) begin
                int k;
                k = (m_rr + off) % NK;
                if (g < 0 && (m_s[k] || m_l[k])) g = k;
            end
        end
        if (g >= 0) gl = m_l[g];
        for (int k = 0; k < NK; k++) begin
            bit took_l;
            bit took_s;
            took_l = (g == k) && gl;
            took_s = (g == k) && !gl;
            if (lp[k] && m_l[k] && !took_l) drop = 1'b1;
            if (sp[k] && m_s[k] && !took_s) drop = 1'b1;
            m_l[k] = (m_l[k] && !took_l) || lp[k];
            m_s[k] = (m_s[k] && !took_s) || sp[k];
        end
        if (rdy && m_q.size() > 0) void'(m_q.pop_front());
        if (g >= 0) begin
            m_q.push_back(g * 2 + int'(gl));
            m_rr = (g + 1) % NK;
        end
        m_ovf = drop || (m_ovf && !clr);
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 32'(evt_valid), 32'(m_q.size() != 0));
        chk({tag, ".cnt"}, 32'(pending_cnt), 32'(m_q.size()));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        if (m_q.size() != 0) begin
            chk({tag, ".key"}, 32'(evt_key), 32'(m_q[0] / 2));
            chk({tag, ".long"}, 32'(evt_long), 32'(m_q[0] % 2));
        end
    endtask

    // Called #1 after an edge; advances one clock and checks against the model
    task automatic tick(input string tag);
        model_edge(short_press, long_press, evt_ready, clr_overflow);
        @(posedge clk_db);
        #1;
        check_all(tag);
    endtask

    task automatic pulse(input string tag, input logic [NK-1:0] s, input logic [NK-1:0] l);
        short_press = s;
        long_press  = l;
        tick(tag);
        short_press = '0;
        long_press  = '0;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock
    task automatic do_reset(input string tag);
        short_press  = '0;
        long_press   = '0;
        evt_ready    = 1'b0;
        clr_overflow = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all({tag, ".async"});
        chk({tag, ".key0"}, 32'(evt_key), 32'd0);
        chk({tag, ".long0"}, 32'(evt_long), 32'd0);
        @(posedge clk_db);
        #1;
        check_all({tag, ".hold"});
        rst = 1'b0;
    endtask

    initial begin
        int exp_k [4];
        int exp_l [4];

        do_reset("init");

        // Single short press on key 2, visible two edges later
        pulse("single_p", 4'b0100, 4'b0000);
        chk("single_notyet", 32'(evt_valid), 32'd0);
        idle("single_w", 1);
        chk("single_valid", 32'(evt_valid), 32'd1);
        chk("single_key", 32'(evt_key), 32'd2);
        chk("single_long", 32'(evt_long), 32'd0);
        chk("single_cnt", 32'(pending_cnt), 32'd1);
        evt_ready = 1'b1;
        tick("single_pop");
        evt_ready = 1'b0;
        chk("single_empty", 32'(evt_valid), 32'd0);
        chk("single_cnt0", 32'(pending_cnt), 32'd0);
        evt_ready = 1'b1;
        tick("empty_pop_ignored");
        evt_ready = 1'b0;

        // Simultaneous pulses on keys 0,1,3 from rr_ptr=0
        do_reset("simul_rst");
        pulse("simul_p", 4'b1011, 4'b0000);
        idle("simul_w", 3);
        chk("simul_cnt", 32'(pending_cnt), 32'd3);
        chk("simul_ovf", 32'(overflow), 32'd0);
        exp_k = '{0, 1, 3, 0};
        evt_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("simul_order", 32'(evt_key), 32'(exp_k[i]));
            tick("simul_drain");
        end
        evt_ready = 1'b0;

        // Long priority and round-robin from rr_ptr=1
        do_reset("rr_rst");
        pulse("rr_k0", 4'b0001, 4'b0000);
        idle("rr_k0w", 1);
        pulse("rr_p", 4'b0110, 4'b0010);
        idle("rr_w", 3);
        chk("rr_cnt", 32'(pending_cnt), 32'd4);
        exp_k = '{0, 1, 2, 1};
        exp_l = '{0, 1, 0, 0};
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("rr_key", 32'(evt_key), 32'(exp_k[i]));
            chk("rr_long", 32'(evt_long), 32'(exp_l[i]));
            tick("rr_drain");
        end
        evt_ready = 1'b0;

        // Full FIFO, waiting event, drop, then refill after one pop
        do_reset("full_rst");
        pulse("full_p", 4'b1111, 4'b0000);
        idle("full_w", 4);
        chk("full_cnt", 32'(pending_cnt), 32'd4);
        pulse("full_wait", 4'b0001, 4'b0000);
        chk("full_noovf", 32'(overflow), 32'd0);
        pulse("full_drop", 4'b0001, 4'b0000);
        chk("full_ovf", 32'(overflow), 32'd1);
        chk("full_cnt4", 32'(pending_cnt), 32'd4);
        evt_ready = 1'b1;
        tick("full_pop");
        evt_ready = 1'b0;
        chk("full_cnt3", 32'(pending_cnt), 32'd3);
        tick("full_refill");
        chk("full_cnt4b", 32'(pending_cnt), 32'd4);
        pulse("ovf_latch", 4'b0001, 4'b0000);
        clr_overflow = 1'b1;
        pulse("ovf_setdom", 4'b0001, 4'b0000);
        chk("ovf_setdom", 32'(overflow), 32'd1);
        tick("ovf_clr");
        clr_overflow = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Same-cycle grant and re-pulse on key 3
        do_reset("regrant_rst");
        pulse("regrant_p1", 4'b1000, 4'b0000);
        pulse("regrant_p2", 4'b1000, 4'b0000);
        idle("regrant_w", 2);
        chk("regrant_cnt", 32'(pending_cnt), 32'd2);
        chk("regrant_ovf", 32'(overflow), 32'd0);
        chk("regrant_key", 32'(evt_key), 32'd3);

        // Async reset with three events queued
        do_reset("mid_rst0");
        pulse("mid_p", 4'b0111, 4'b0000);
        idle("mid_w", 3);
        chk("mid_cnt", 32'(pending_cnt), 32'd3);
        do_reset("mid_rst");
        idle("mid_after", 3);
        chk("mid_stale", 32'(evt_valid), 32'd0);

        // Random traffic
        do_reset("rand_rst");
        for (int c = 0; c < 600; c++) begin
            logic [NK-1:0] s;
            logic [NK-1:0] l;
            for (int k = 0; k < NK; k++) begin
                s[k] = ($urandom_range(0, 5) == 0);
                l[k] = ($urandom_range(0, 7) == 0);
            end
            short_press  = s;
            long_press   = l;
            evt_ready    = ((c / 64) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                               : ($urandom_range(0, 3) == 0);
            clr_overflow = ($urandom_range(0, 15) == 0);
            tick("rand");
        end
        short_press  = '0;
        long_press   = '0;
        clr_overflow = 1'b0;
        evt_ready    = 1'b1;
        idle("rand_drain", 16);
        chk("rand_final_cnt", 32'(pending_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
